// File: rtl/seq_mul.sv
// Iterative shift-add multiplier, N x N -> 2N bits, one partial product per clock.
// Define SEQ_MUL_SIGNED_EN for two's complement operands and product; ports and timing are unchanged.
module seq_mul #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mult_q,  mult_d;
  logic [2*N-1:0] acc_q,   acc_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [2*N-1:0] p_q,     p_d;

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [2*N-1:0] acc_sum;
  logic [2*N-1:0] result;

`ifdef SEQ_MUL_SIGNED_EN
  logic neg_q, neg_d;

  // -2^(N-1) negates to itself, which read as unsigned is the correct magnitude.
  always_comb begin
    mag_a = a[N-1] ? -a : a;
    mag_b = b[N-1] ? -b : b;
  end

  always_comb begin
    neg_d = neg_q;
    if (state_q == S_IDLE && start) begin
      neg_d = a[N-1] ^ b[N-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign result = neg_q ? -acc_sum : acc_sum;
`else
  always_comb begin
    mag_a = a;
    mag_b = b;
  end

  assign result = acc_sum;
`endif

  // The multiplier is consumed from its LSB, so bit cnt of b is always mult_q[0].
  assign acc_sum = mult_q[0] ? (acc_q + ({{N{1'b0}}, mcand_q} << cnt_q)) : acc_q;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = mag_a;
          mult_d  = mag_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d  = acc_sum;
        mult_d = mult_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          p_d     = result;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign p     = p_q;

endmodule

// File: tb/tb_seq_mul.sv
// Directed and random checks of seq_mul at N=4 and N=8 with a product/latency scoreboard.
module tb_seq_mul;

  logic clk;
  logic rst;

  logic       s4_start, s4_ready, s4_busy, s4_done;
  logic [3:0] s4_a, s4_b;
  logic [7:0] s4_p;

  logic        s8_start, s8_ready, s8_busy, s8_done;
  logic [7:0]  s8_a, s8_b;
  logic [15:0] s8_p;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc4 = 0, dones4 = 0, acc8 = 0, dones8 = 0;
  logic prev4 = 1'b0, prev8 = 1'b0;

  logic [63:0] q4[$], q8[$];
  int          k4[$], k8[$];

  seq_mul #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4_start), .a(s4_a), .b(s4_b),
    .ready(s4_ready), .busy(s4_busy), .done(s4_done), .p(s4_p)
  );

  seq_mul #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b),
    .ready(s8_ready), .busy(s8_busy), .done(s8_done), .p(s8_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input longint x, input longint y, input int w);
    longint sx = x, sy = y;
`ifdef SEQ_MUL_SIGNED_EN
    if (sx >= (longint'(1) << (w - 1))) sx -= (longint'(1) << w);
    if (sy >= (longint'(1) << (w - 1))) sy -= (longint'(1) << w);
`endif
    return 64'((sx * sy) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Drives one start at the next idle negedge; returns the cycle index of the accepting edge.
  task automatic accept4(input logic [3:0] x, input logic [3:0] y, output int k);
    int t = 0;
    @(negedge clk);
    while (!s4_ready && t < 50) begin @(negedge clk); t++; end
    if (!s4_ready) check("ready4_timeout", 64'(s4_ready), 64'd1);
    s4_a = x; s4_b = y; s4_start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    s4_start = 1'b0;
    acc4++;
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y);
    int k;
    accept4(x, y, k);
    q4.push_back(ref_mul(longint'(x), longint'(y), 4));
    k4.push_back(k);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    int t = 0;
    @(negedge clk);
    while (!s8_ready && t < 50) begin @(negedge clk); t++; end
    if (!s8_ready) check("ready8_timeout", 64'(s8_ready), 64'd1);
    s8_a = x; s8_b = y; s8_start = 1'b1;
    @(posedge clk); #1;
    q8.push_back(ref_mul(longint'(x), longint'(y), 8));
    k8.push_back(cyc);
    s8_start = 1'b0;
    acc8++;
  endtask

  task automatic drain4();
    int t = 0;
    while ((q4.size() != 0 || !s4_ready) && t < 100) begin @(negedge clk); t++; end
    if (q4.size() != 0) check("drain4_timeout", 64'(q4.size()), 64'd0);
  endtask

  task automatic drain8();
    int t = 0;
    while ((q8.size() != 0 || !s8_ready) && t < 100) begin @(negedge clk); t++; end
    if (q8.size() != 0) check("drain8_timeout", 64'(q8.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rdy_busy_excl4", 64'(s4_ready & s4_busy), 64'd0);
      if (s4_done) begin
        check("done4_pulse", 64'(prev4), 64'd0);
        dones4++;
        if (q4.size() == 0) check("done4_unexpected", 64'd1, 64'd0);
        else begin
          check("p4", 64'(s4_p), q4.pop_front());
          check("lat4", 64'(cyc), 64'(k4.pop_front() + 4));
        end
      end
      if (s8_done) begin
        check("done8_pulse", 64'(prev8), 64'd0);
        dones8++;
        if (q8.size() == 0) check("done8_unexpected", 64'd1, 64'd0);
        else begin
          check("p8", 64'(s8_p), q8.pop_front());
          check("lat8", 64'(cyc), 64'(k8.pop_front() + 8));
        end
      end
    end
    prev4 <= s4_done;
    prev8 <= s8_done;
  end

  initial begin
    int k;
    rst = 1'b1;
    s4_start = 1'b0; s4_a = '0; s4_b = '0;
    s8_start = 1'b0; s8_a = '0; s8_b = '0;
    #12;
    check("rst_ready", 64'(s4_ready), 64'd1);
    check("rst_busy",  64'(s4_busy),  64'd0);
    check("rst_done",  64'(s4_done),  64'd0);
    check("rst_p",     64'(s4_p),     64'd0);
    @(negedge clk); rst = 1'b0;

    op4(4'd15, 4'd15);
    drain4();
`ifndef SEQ_MUL_SIGNED_EN
    check("p_15x15", 64'(s4_p), 64'hE1);
`endif

    op4(4'd0, 4'd9);
    op4(4'd9, 4'd0);
    drain4();
    check("p_zero", 64'(s4_p), 64'd0);

    // Extra starts while not ready must be ignored.
    op4(4'd2, 4'd3);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      s4_start = 1'b1;
      s4_a = 4'($urandom);
      s4_b = 4'($urandom);
    end
    @(negedge clk); s4_start = 1'b0;
    drain4();
    check("p_ignore", 64'(s4_p), 64'd6);

    // Abort mid-RUN: no result expected.
    accept4(4'd7, 4'd7, k);
    acc4--;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("abort_ready", 64'(s4_ready), 64'd1);
    check("abort_busy",  64'(s4_busy),  64'd0);
    check("abort_done",  64'(s4_done),  64'd0);
    check("abort_p",     64'(s4_p),     64'd0);
    @(negedge clk); rst = 1'b0;
    op4(4'd3, 4'd5);
    drain4();
    check("p_3x5", 64'(s4_p), 64'd15);

`ifdef SEQ_MUL_SIGNED_EN
    op4(4'h8, 4'h8); drain4(); check("s_m8xm8", 64'(s4_p), 64'h40);
    op4(4'hD, 4'h5); drain4(); check("s_m3x5",  64'(s4_p), 64'hF1);
    op4(4'h7, 4'hF); drain4(); check("s_7xm1",  64'(s4_p), 64'hF9);
`endif

    fork
      for (int i = 0; i < 1000; i++) op4(4'($urandom), 4'($urandom));
      for (int j = 0; j < 1000; j++) op8(8'($urandom), 8'($urandom));
    join
    drain4();
    drain8();
    check("count4", 64'(dones4), 64'(acc4));
    check("count8", 64'(dones8), 64'(acc8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
